// File: rtl/array_heap.sv
// array_heap: handshaked heap of fixed-capacity arrays with a LIFO free list, scans and shifts
module array_heap #(
    parameter int ADDRESS_BITS = 4,
    parameter int INDEX_BITS = 3,
    parameter int DATA_BITS = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic req_valid,
    output logic req_ready,
    input  logic [7:0] req_action,
    input  logic [ADDRESS_BITS-1:0] req_array,
    input  logic [INDEX_BITS-1:0] req_index,
    input  logic [DATA_BITS-1:0] req_in,
    output logic rsp_valid,
    output logic [DATA_BITS-1:0] rsp_out,
    output logic [3:0] rsp_error
);
    localparam int ARRAYS = 2 ** ADDRESS_BITS;
    localparam int ARRAY_LENGTH = 2 ** INDEX_BITS;
    localparam logic [ADDRESS_BITS:0] arrays_n = (ADDRESS_BITS + 1)'(ARRAYS);
    localparam logic [INDEX_BITS:0] len_s = (INDEX_BITS + 1)'(ARRAY_LENGTH);
    localparam logic [DATA_BITS-1:0] len_d = DATA_BITS'(ARRAY_LENGTH);
    localparam logic [INDEX_BITS-1:0] last_cnt = INDEX_BITS'(ARRAY_LENGTH - 1);
    localparam logic [7:0] OP_RESET = 8'd1;
    localparam logic [7:0] OP_WRITE = 8'd2;
    localparam logic [7:0] OP_READ = 8'd3;
    localparam logic [7:0] OP_SIZE = 8'd4;
    localparam logic [7:0] OP_INDEX = 8'd7;
    localparam logic [7:0] OP_LESS = 8'd8;
    localparam logic [7:0] OP_GREATER = 8'd9;
    localparam logic [7:0] OP_UP = 8'd10;
    localparam logic [7:0] OP_DOWN = 8'd11;
    localparam logic [7:0] OP_PUSH = 8'd14;
    localparam logic [7:0] OP_POP = 8'd15;
    localparam logic [7:0] OP_ALLOC = 8'd18;
    localparam logic [7:0] OP_FREE = 8'd19;

    typedef enum logic [1:0] {IDLE, SCAN, SHIFT, RESP} state_t;

    state_t state;
    state_t next_state;
    logic [DATA_BITS-1:0] mem [ARRAYS][ARRAY_LENGTH];
    logic [INDEX_BITS:0] size [ARRAYS];
    logic [ARRAYS-1:0] allocated;
    logic [ADDRESS_BITS-1:0] free_stack [ARRAYS];
    logic [ADDRESS_BITS:0] free_count;
    logic [ADDRESS_BITS:0] high_water;
    logic [7:0] op;
    logic [ADDRESS_BITS-1:0] arr;
    logic [INDEX_BITS-1:0] idx;
    logic [DATA_BITS-1:0] din;
    logic [INDEX_BITS:0] sz;
    logic [INDEX_BITS-1:0] cnt;
    logic [DATA_BITS-1:0] acc;
    logic [DATA_BITS-1:0] acc_next;
    logic [DATA_BITS-1:0] scan_elem;
    logic in_range;
    logic accept;
    logic do_op;
    logic clear;
    logic known;
    logic is_scan;
    logic is_shift;
    logic [3:0] err;
    logic [INDEX_BITS:0] cur_size;
    logic cur_alloc;
    logic [DATA_BITS-1:0] cur_elem;
    logic [DATA_BITS-1:0] top_elem;
    logic [ADDRESS_BITS-1:0] alloc_id;
    logic [DATA_BITS-1:0] imm_out;
    logic [INDEX_BITS-1:0] pos;
    logic [INDEX_BITS-1:0] shift_src;
    logic up_we;
    logic down_we;
    logic mem_we;
    logic [ADDRESS_BITS-1:0] mem_a;
    logic [INDEX_BITS-1:0] mem_i;
    logic [DATA_BITS-1:0] mem_d;
    logic shift_done;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign accept = req_valid && req_ready;
    assign do_op = accept && err == '0;
    assign clear = reset || (do_op && req_action == OP_RESET);
    assign cur_size = size[req_array];
    assign cur_alloc = allocated[req_array];
    assign cur_elem = mem[req_array][req_index];
    assign top_elem = mem[req_array][INDEX_BITS'(cur_size - 1'b1)];
    assign alloc_id = (free_count != '0) ? free_stack[ADDRESS_BITS'(free_count - 1'b1)] : high_water[ADDRESS_BITS-1:0];
    assign known = req_action inside {OP_RESET, OP_WRITE, OP_READ, OP_SIZE, OP_INDEX, OP_LESS, OP_GREATER,
                                      OP_UP, OP_DOWN, OP_PUSH, OP_POP, OP_ALLOC, OP_FREE};
    assign is_scan = req_action inside {OP_INDEX, OP_LESS, OP_GREATER};
    assign is_shift = req_action inside {OP_UP, OP_DOWN};
    assign shift_done = state == SHIFT && cnt == last_cnt;

    // acceptance checks in priority order, evaluated against current state
    always_comb begin
        err = 4'd0;
        if (!known) err = 4'd7;
        else if (req_action == OP_ALLOC) err = (free_count == '0 && high_water == arrays_n) ? 4'd5 : 4'd0;
        else if (req_action == OP_FREE) err = cur_alloc ? 4'd0 : 4'd6;
        else if (req_action != OP_RESET && !cur_alloc) err = 4'd1;
        else if ((req_action == OP_POP || req_action == OP_DOWN) && cur_size == '0) err = 4'd4;
        else if ((req_action == OP_PUSH || req_action == OP_UP) && cur_size == len_s) err = 4'd3;
        else if ((req_action == OP_WRITE || req_action == OP_READ || req_action == OP_DOWN) && {1'b0, req_index} >= cur_size) err = 4'd2;
        else if (req_action == OP_UP && {1'b0, req_index} > cur_size) err = 4'd2;
    end

    // immediate result of a single-cycle op
    always_comb begin
        imm_out = (req_action == OP_WRITE) ? req_in :
                  (req_action == OP_READ) ? cur_elem :
                  (req_action == OP_SIZE) ? DATA_BITS'(cur_size) :
                  (req_action == OP_PUSH) ? DATA_BITS'(cur_size + 1'b1) :
                  (req_action == OP_POP) ? top_elem :
                  (req_action == OP_ALLOC) ? DATA_BITS'(alloc_id) : '0;
    end

    // one-element step of Less/Greater/Index; Index keeps the first hit only
    always_comb begin
        scan_elem = mem[arr][cnt];
        in_range = {1'b0, cnt} < sz;
        acc_next = acc;
        if (state == SCAN && in_range) begin
            if (op == OP_LESS && scan_elem < din) acc_next = acc + 1'b1;
            if (op == OP_GREATER && scan_elem > din) acc_next = acc + 1'b1;
            if (op == OP_INDEX && scan_elem == din && acc == len_d) acc_next = DATA_BITS'(cnt);
        end
    end

    // shift walks top-down for Up and bottom-up for Down so sources are read before being overwritten
    always_comb begin
        pos = (op == OP_UP) ? last_cnt - cnt : cnt;
        shift_src = (op == OP_UP) ? pos - 1'b1 : pos + 1'b1;
        up_we = state == SHIFT && op == OP_UP && pos >= idx && {1'b0, pos} <= sz;
        down_we = state == SHIFT && op == OP_DOWN && pos >= idx && {1'b0, pos} + 1'b1 < sz;
        mem_we = (do_op && (req_action == OP_WRITE || req_action == OP_PUSH)) || up_we || down_we;
        mem_a = do_op ? req_array : arr;
        mem_i = do_op ? ((req_action == OP_PUSH) ? cur_size[INDEX_BITS-1:0] : req_index) : pos;
        mem_d = do_op ? req_in : (up_we && pos == idx) ? din : mem[arr][shift_src];
    end

    // next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (accept) next_state = (err != '0) ? RESP : is_scan ? SCAN : is_shift ? SHIFT : RESP;
            SCAN, SHIFT: if (cnt == last_cnt) next_state = RESP;
            default: next_state = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clock) begin
        state <= reset ? IDLE : next_state;
    end

    // element storage; never cleared, stale contents sit beyond size
    always_ff @(posedge clock) begin
        if (!reset && mem_we) mem[mem_a][mem_i] <= mem_d;
    end

    // sizes, allocation flags, free stack and high-water counter
    always_ff @(posedge clock) begin
        if (clear) begin
            for (int k = 0; k < ARRAYS; k++) size[k] <= '0;
            allocated <= '0;
            free_count <= '0;
            high_water <= '0;
        end else if (do_op) begin
            case (req_action)
                OP_PUSH: size[req_array] <= cur_size + 1'b1;
                OP_POP: size[req_array] <= cur_size - 1'b1;
                OP_ALLOC: begin
                    allocated[alloc_id] <= 1'b1;
                    size[alloc_id] <= '0;
                    if (free_count != '0) free_count <= free_count - 1'b1;
                    else high_water <= high_water + 1'b1;
                end
                OP_FREE: begin
                    allocated[req_array] <= 1'b0;
                    size[req_array] <= '0;
                    free_stack[free_count[ADDRESS_BITS-1:0]] <= req_array;
                    free_count <= free_count + 1'b1;
                end
                default: ;
            endcase
        end else if (shift_done) size[arr] <= (op == OP_UP) ? sz + 1'b1 : sz - 1'b1;
    end

    // request latch, scan accumulator and response registers held until the next response
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            rsp_out <= '0;
            rsp_error <= '0;
        end else if (accept) begin
            op <= req_action;
            arr <= req_array;
            idx <= req_index;
            din <= req_in;
            sz <= cur_size;
            cnt <= '0;
            acc <= (req_action == OP_INDEX) ? len_d : (req_action == OP_DOWN) ? cur_elem : '0;
            if (err != '0 || !(is_scan || is_shift)) begin
                rsp_error <= err;
                rsp_out <= (err != '0) ? '0 : imm_out;
            end
        end else if (state == SCAN || state == SHIFT) begin
            cnt <= cnt + 1'b1;
            acc <= acc_next;
            if (cnt == last_cnt) begin
                rsp_error <= '0;
                rsp_out <= (state == SHIFT && op == OP_UP) ? DATA_BITS'(sz + 1'b1) : acc_next;
            end
        end
    end
endmodule

// File: tb/tb_array_heap.sv
// tb_array_heap: table-driven directed vectors plus busy/reset corner sequences for array_heap
module tb_array_heap;
    localparam logic [7:0] RST = 8'd1;
    localparam logic [7:0] WR = 8'd2;
    localparam logic [7:0] RD = 8'd3;
    localparam logic [7:0] SZ = 8'd4;
    localparam logic [7:0] IX = 8'd7;
    localparam logic [7:0] LT = 8'd8;
    localparam logic [7:0] GT = 8'd9;
    localparam logic [7:0] UP = 8'd10;
    localparam logic [7:0] DN = 8'd11;
    localparam logic [7:0] PU = 8'd14;
    localparam logic [7:0] PO = 8'd15;
    localparam logic [7:0] AL = 8'd18;
    localparam logic [7:0] FR = 8'd19;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic req_valid = 1'b0;
    logic req_ready;
    logic [7:0] req_action = '0;
    logic [3:0] req_array = '0;
    logic [2:0] req_index = '0;
    logic [15:0] req_in = '0;
    logic rsp_valid;
    logic [15:0] rsp_out;
    logic [3:0] rsp_error;
    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [7:0] act;
        logic [3:0] arr;
        logic [2:0] idx;
        logic [15:0] din;
        logic [15:0] out;
        logic [3:0] err;
        int lat;
    } vec_t;
    vec_t vecs[$];

    always #5 clock = ~clock;

    array_heap #(.ADDRESS_BITS(4), .INDEX_BITS(3), .DATA_BITS(16)) dut (
        .clock(clock),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_action(req_action),
        .req_array(req_array),
        .req_index(req_index),
        .req_in(req_in),
        .rsp_valid(rsp_valid),
        .rsp_out(rsp_out),
        .rsp_error(rsp_error)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic add(input logic [7:0] a, input logic [3:0] r, input logic [2:0] i, input logic [15:0] d,
                       input logic [15:0] o, input logic [3:0] e, input int l);
        vec_t v;
        v.act = a;
        v.arr = r;
        v.idx = i;
        v.din = d;
        v.out = o;
        v.err = e;
        v.lat = l;
        vecs.push_back(v);
    endtask

    task automatic issue(input logic [7:0] a, input logic [3:0] r, input logic [2:0] i, input logic [15:0] d,
                         output logic [15:0] o, output logic [3:0] e, output int lat);
        int w;
        w = 0;
        @(negedge clock);
        while (!req_ready && w < 50) begin
            @(negedge clock);
            w++;
        end
        req_valid = 1'b1;
        req_action = a;
        req_array = r;
        req_index = i;
        req_in = d;
        @(posedge clock);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!rsp_valid && lat < 50);
        if (!rsp_valid) lat = -1;
        o = rsp_out;
        e = rsp_error;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    initial begin
        logic [15:0] o;
        logic [3:0] e;
        int lat;
        int busy;
        int seen;
        for (int k = 0; k < 16; k++) add(AL, 0, 0, 0, 16'(k), 0, 1);
        add(AL, 0, 0, 0, 0, 5, 1);
        add(FR, 3, 0, 0, 0, 0, 1);
        add(AL, 0, 0, 0, 3, 0, 1);
        add(FR, 3, 0, 0, 0, 0, 1);
        add(FR, 3, 0, 0, 0, 6, 1);
        add(RD, 3, 0, 0, 0, 1, 1);
        add(PO, 3, 0, 0, 0, 1, 1);
        add(8'd99, 3, 0, 0, 0, 7, 1);
        add(8'd99, 0, 0, 0, 0, 7, 1);
        add(PU, 0, 0, 10, 1, 0, 1);
        add(PU, 0, 0, 20, 2, 0, 1);
        add(PU, 0, 0, 30, 3, 0, 1);
        add(PO, 0, 0, 0, 30, 0, 1);
        add(SZ, 0, 0, 0, 2, 0, 1);
        add(PO, 0, 0, 0, 20, 0, 1);
        add(PO, 0, 0, 0, 10, 0, 1);
        add(PO, 0, 0, 0, 0, 4, 1);
        add(PU, 1, 0, 5, 1, 0, 1);
        add(PU, 1, 0, 7, 2, 0, 1);
        add(PU, 1, 0, 9, 3, 0, 1);
        add(UP, 1, 1, 6, 4, 0, 9);
        add(RD, 1, 0, 0, 5, 0, 1);
        add(RD, 1, 1, 0, 6, 0, 1);
        add(RD, 1, 2, 0, 7, 0, 1);
        add(RD, 1, 3, 0, 9, 0, 1);
        add(DN, 1, 0, 0, 5, 0, 9);
        add(RD, 1, 0, 0, 6, 0, 1);
        add(RD, 1, 1, 0, 7, 0, 1);
        add(RD, 1, 2, 0, 9, 0, 1);
        add(SZ, 1, 0, 0, 3, 0, 1);
        add(RD, 1, 3, 0, 0, 2, 1);
        add(WR, 1, 1, 77, 77, 0, 1);
        add(RD, 1, 1, 0, 77, 0, 1);
        add(WR, 1, 3, 5, 0, 2, 1);
        add(PU, 2, 0, 3, 1, 0, 1);
        add(PU, 2, 0, 8, 2, 0, 1);
        add(PU, 2, 0, 8, 3, 0, 1);
        add(PU, 2, 0, 1, 4, 0, 1);
        add(LT, 2, 0, 8, 2, 0, 9);
        add(GT, 2, 0, 3, 2, 0, 9);
        add(IX, 2, 0, 8, 1, 0, 9);
        add(IX, 2, 0, 4, 8, 0, 9);
        add(PO, 2, 0, 0, 1, 0, 1);
        add(IX, 2, 0, 1, 8, 0, 9);
        add(LT, 2, 0, 9, 3, 0, 9);
        for (int k = 1; k <= 8; k++) add(PU, 4, 0, 16'(k), 16'(k), 0, 1);
        add(PU, 4, 0, 0, 0, 3, 1);
        add(UP, 4, 0, 0, 0, 3, 1);
        add(UP, 4, 7, 0, 0, 3, 1);
        add(UP, 5, 0, 42, 1, 0, 9);
        add(RD, 5, 0, 0, 42, 0, 1);
        add(UP, 5, 2, 0, 0, 2, 1);
        add(DN, 5, 1, 0, 0, 2, 1);
        add(UP, 5, 1, 43, 2, 0, 9);
        add(RD, 5, 1, 0, 43, 0, 1);
        add(RD, 5, 0, 0, 42, 0, 1);
        add(DN, 6, 0, 0, 0, 4, 1);
        add(PO, 6, 0, 0, 0, 4, 1);
        add(DN, 6, 3, 0, 0, 4, 1);
        add(LT, 7, 0, 5, 0, 0, 9);
        add(IX, 7, 0, 0, 8, 0, 9);
        add(RST, 0, 0, 0, 0, 0, 1);
        add(SZ, 0, 0, 0, 0, 1, 1);
        add(RD, 5, 0, 0, 0, 1, 1);
        add(AL, 0, 0, 0, 0, 0, 1);
        add(AL, 0, 0, 0, 1, 0, 1);
        add(PU, 0, 0, 4, 1, 0, 1);
        add(PU, 0, 0, 9, 2, 0, 1);

        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("reset req_ready", req_ready, 1);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_out", rsp_out, 0);
        check("reset rsp_error", rsp_error, 0);

        for (int n = 0; n < vecs.size(); n++) begin
            issue(vecs[n].act, vecs[n].arr, vecs[n].idx, vecs[n].din, o, e, lat);
            check($sformatf("v%0d act%0d out", n, vecs[n].act), o, vecs[n].out);
            check($sformatf("v%0d act%0d error", n, vecs[n].act), e, vecs[n].err);
            check($sformatf("v%0d act%0d latency", n, vecs[n].act), lat, vecs[n].lat);
            @(negedge clock);
            check($sformatf("v%0d pulse width", n), rsp_valid, 0);
            check($sformatf("v%0d out hold", n), rsp_out, vecs[n].out);
        end

        @(negedge clock);
        req_valid = 1'b1;
        req_action = GT;
        req_array = 4'd0;
        req_index = 3'd0;
        req_in = 16'd3;
        @(posedge clock);
        #1 req_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("abort req_ready", req_ready, 1);
        check("abort rsp_valid", rsp_valid, 0);
        seen = 0;
        repeat (12) begin
            @(negedge clock);
            if (rsp_valid) seen++;
        end
        check("abort no response", seen, 0);
        check("abort rsp_out", rsp_out, 0);

        issue(AL, 0, 0, 0, o, e, lat);
        check("held alloc out", o, 0);
        issue(PU, 0, 0, 1, o, e, lat);
        check("held push out", o, 1);
        @(negedge clock);
        req_valid = 1'b1;
        req_action = UP;
        req_array = 4'd0;
        req_index = 3'd0;
        req_in = 16'd2;
        @(posedge clock);
        #1 req_action = SZ;
        lat = 0;
        busy = 0;
        do begin
            @(negedge clock);
            lat++;
            if (req_ready && !rsp_valid) busy++;
        end while (!rsp_valid && lat < 50);
        check("held up latency", lat, 9);
        check("held up out", rsp_out, 2);
        check("held ready during shift", busy, 0);
        @(posedge clock);
        @(negedge clock);
        check("held ready in idle", req_ready, 1);
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("held size valid", rsp_valid, 1);
        check("held size out", rsp_out, 2);
        check("held size error", rsp_error, 0);
        issue(RD, 0, 0, 0, o, e, lat);
        check("held read 0", o, 2);
        issue(RD, 0, 1, 0, o, e, lat);
        check("held read 1", o, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
